// File: rtl/hash_pkg.sv
// Shared constants and types for the hash front-end: block geometry,
// assembler state encoding and the flat block type.
package hash_pkg;
  localparam int C_WORD_W      = 32;
  localparam int C_BLOCK_WORDS = 16;
  localparam int C_BLOCK_W     = 512;
  localparam int C_LEN_W       = 64;

  localparam logic [C_WORD_W-1:0] C_MARKER_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {S_FILL, S_LEN, S_OUT} asm_state_t;
  typedef logic [C_BLOCK_W-1:0] block_t;
endpackage

// File: rtl/msg_block_assembler_if.sv
// Message-word input stream and padded-block output handshake of the
// block assembler; slave is the assembler's view, master the producer/consumer.
interface msg_block_assembler_if;
  import hash_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [C_WORD_W-1:0] in_data;
  logic                in_last;
  logic [1:0]          in_bytes;
  logic                blk_valid;
  logic                blk_ready;
  block_t              blk_data;
  logic                blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/msg_block_assembler_byte_pad_mask.sv
// Masks the unused low bytes of a final message word and places the 0x80
// marker after the last valid byte; a full word pushes the marker onward.
module byte_pad_mask
  import hash_pkg::*;
(
  input  logic [C_WORD_W-1:0] data,
  input  logic [1:0]          bytes,
  output logic [C_WORD_W-1:0] padded,
  output logic                spill
);

  always_comb begin
    padded = data;
    spill  = 1'b0;
    case (bytes)
      2'd0:    spill  = 1'b1;
      2'd1:    padded = {data[31:24], 24'h80_0000};
      2'd2:    padded = {data[31:16], 16'h8000};
      default: padded = {data[31:8], 8'h80};
    endcase
  end

endmodule

// File: rtl/msg_block_assembler.sv
// Packs a stream of big-endian message words into padded 512-bit blocks
// (0x80 marker, zero fill, 64-bit bit length) for the hash block register.
module msg_block_assembler
  import hash_pkg::*;
#(
  parameter int p_wordSize   = 32,
  parameter int p_blockWords = 16,
  parameter int p_lenSize    = 64
) (
  input  logic                  clk,
  input  logic                  rstN,
  msg_block_assembler_if.slave  bus
);

  localparam int CNT_W = p_lenSize - 3;
  localparam int IDX_W = $clog2(p_blockWords);

  localparam logic [1:0] ST_FILL = S_FILL;
  localparam logic [1:0] ST_LEN  = S_LEN;
  localparam logic [1:0] ST_OUT  = S_OUT;

  logic [1:0]            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pend_q;
  logic                  ovf_q;
  logic                  last_q;
  logic [p_wordSize-1:0] words_q [p_blockWords];

  logic                  in_hs;
  logic                  out_hs;
  logic [p_wordSize-1:0] pad_word;
  logic                  spill;
  logic [CNT_W-1:0]      add_bytes;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [CNT_W-1:0]      len_sel;
  logic [p_lenSize-1:0]  len_bits;
  logic                  at_end;
  logic                  len_fits;
  block_t                blk_flat;

  byte_pad_mask u_pad (
    .data   (bus.in_data),
    .bytes  (bus.in_bytes),
    .padded (pad_word),
    .spill  (spill)
  );

  assign in_hs  = bus.in_valid  & (state_q == ST_FILL);
  assign out_hs = bus.blk_ready & (state_q == ST_OUT);

  assign add_bytes = (bus.in_last && bus.in_bytes != 2'd0) ? CNT_W'(bus.in_bytes) : CNT_W'(4);
  assign cnt_nxt   = cnt_q + add_bytes;
  // Length is written with the final word in FILL, or from the settled counter in LEN.
  assign len_sel   = (state_q == ST_LEN) ? cnt_q : cnt_nxt;
  assign len_bits  = {len_sel, 3'b000};

  assign at_end   = (idx_q == IDX_W'(p_blockWords - 1));
  assign len_fits = (int'(idx_q) + (spill ? 1 : 0)) <= (p_blockWords - 3);

  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < p_blockWords; i++)
      blk_flat[p_wordSize*(p_blockWords-i)-1 -: p_wordSize] = words_q[i];
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.blk_valid = (state_q == ST_OUT);
  assign bus.blk_data  = blk_flat;
  assign bus.blk_last  = last_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < p_blockWords; i++) words_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_hs) begin
            idx_q <= idx_q + IDX_W'(1);
            cnt_q <= cnt_nxt;
            if (bus.in_last) begin
              words_q[idx_q] <= pad_word;
              if (spill && !at_end) words_q[idx_q + IDX_W'(1)] <= C_MARKER_WORD;
              if (spill && at_end)  pend_q <= 1'b1;
              // No room for the length field: emit this block, then a length-only block.
              if (len_fits) begin
                words_q[p_blockWords-2] <= len_bits[p_lenSize-1 -: p_wordSize];
                words_q[p_blockWords-1] <= len_bits[p_wordSize-1:0];
                last_q <= 1'b1;
              end else begin
                ovf_q  <= 1'b1;
                last_q <= 1'b0;
              end
              state_q <= ST_OUT;
            end else begin
              words_q[idx_q] <= bus.in_data;
              if (at_end) begin
                last_q  <= 1'b0;
                state_q <= ST_OUT;
              end
            end
          end
        end
        ST_OUT: begin
          if (out_hs) begin
            for (int i = 0; i < p_blockWords; i++) words_q[i] <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            if (last_q) cnt_q <= '0;
            state_q <= ovf_q ? ST_LEN : ST_FILL;
          end
        end
        ST_LEN: begin
          if (pend_q) words_q[0] <= C_MARKER_WORD;
          words_q[p_blockWords-2] <= len_bits[p_lenSize-1 -: p_wordSize];
          words_q[p_blockWords-1] <= len_bits[p_wordSize-1:0];
          pend_q  <= 1'b0;
          ovf_q   <= 1'b0;
          last_q  <= 1'b1;
          state_q <= ST_OUT;
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_block_assembler.sv
// Bench for msg_block_assembler: directed steps plus random messages checked
// against a byte-level padding model.
module tb_msg_block_assembler;
  import hash_pkg::*;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];
  logic         exp_last_q[$];

  msg_block_assembler_if bus();

  msg_block_assembler dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] ABC_BLK = {32'h6162_6380, 448'h0, 32'h0000_0018};
  localparam logic [511:0] BP_BLK  = {32'h1122_3344, 32'h8000_0000, 416'h0, 32'h0000_0020};

  task automatic check_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
  function automatic void build_expected();
    logic [7:0]  p[$];
    logic [63:0] bits;
    int          nblk;
    p    = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      logic [511:0] blk;
      blk = '0;
      for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = p[b*64+k];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endfunction

  task automatic run_msg(input string tag);
    int n;
    int wi;
    int cyc;
    n  = (msg_q.size() + 3) / 4;
    wi = 0;
    exp_q.delete();
    exp_last_q.delete();
    build_expected();
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (wi == n && exp_q.size() == 0) break;
      bus.in_valid  = 1'b0;
      bus.blk_ready = 1'b0;
      if (wi < n) begin
        for (int k = 0; k < 4; k++) begin
          int bi;
          bi = wi * 4 + k;
          bus.in_data[31-8*k -: 8] = (bi < msg_q.size()) ? msg_q[bi] : 8'($urandom);
        end
        bus.in_last  = (wi == n - 1);
        bus.in_bytes = 2'(msg_q.size() % 4);
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      if (bus.blk_valid) begin
        check_bit({tag, "_in_ready_out"}, bus.in_ready, 1'b0);
        bus.blk_ready = ($urandom_range(0, 2) != 0);
        if (bus.blk_ready) begin
          if (exp_q.size() == 0) begin
            check_bit({tag, "_extra_block"}, bus.blk_valid, 1'b0);
          end else begin
            check_blk({tag, "_blk_data"}, bus.blk_data, exp_q.pop_front());
            check_bit({tag, "_blk_last"}, bus.blk_last, exp_last_q.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) wi++;
    end
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;
    check_bit({tag, "_complete"}, (wi == n) && (exp_q.size() == 0), 1'b1);
  endtask

  task automatic set_msg_bytes(input int len);
    msg_q.delete();
    for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = 2'd0;
    bus.blk_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_bit("rst_blk_valid", bus.blk_valid, 1'b0);
    check_bit("rst_blk_last", bus.blk_last, 1'b0);
    check_blk("rst_blk_data", bus.blk_data, '0);
    rstN = 1'b1;
    @(negedge clk);
    check_bit("post_rst_in_ready", bus.in_ready, 1'b1);

    // "abc" directed, one-cycle latency
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h6162_6300;
    bus.in_bytes = 2'd3;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_bit("abc_latency_valid", bus.blk_valid, 1'b1);
    check_blk("abc_blk_data", bus.blk_data, ABC_BLK);
    check_bit("abc_blk_last", bus.blk_last, 1'b1);
    check_bit("abc_in_ready", bus.in_ready, 1'b0);
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
    check_bit("abc_after_valid", bus.blk_valid, 1'b0);
    check_bit("abc_after_in_ready", bus.in_ready, 1'b1);

    // Backpressure: block held for 5 cycles while input is offered
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1122_3344;
    bus.in_bytes = 2'd0;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_bit("bp_valid", bus.blk_valid, 1'b1);
      check_blk("bp_hold_data", bus.blk_data, BP_BLK);
      check_bit("bp_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_bit("bp_release_valid", bus.blk_valid, 1'b0);
    check_bit("bp_release_in_ready", bus.in_ready, 1'b1);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("bp_followup_abc");

    // Reset part-way through a message
    for (int w = 0; w < 7; w++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom | 32'h1;
      bus.in_last  = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    check_blk("midrst_blk_data", bus.blk_data, '0);
    check_bit("midrst_blk_valid", bus.blk_valid, 1'b0);
    check_bit("midrst_blk_last", bus.blk_last, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("midrst_abc");

    // Boundary lengths: marker spills past length field, full-block message
    set_msg_bytes(56);
    run_msg("len56");
    set_msg_bytes(64);
    run_msg("len64");
    set_msg_bytes(55);
    run_msg("len55");

    // Back-to-back messages, counter restarts
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("b2b_abc");
    msg_q = '{8'h64};
    run_msg("b2b_d");

    // Random messages
    for (int r = 0; r < 10; r++) begin
      set_msg_bytes($urandom_range(1, 150));
      run_msg("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
